// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART RX control path:
// FSM state codes, prescale width and legal ratios.
package uart_rx_pkg;

  localparam int PRESC_W = 6;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  function automatic logic presc_legal(input int p);
    return (p == PRESC_8) || (p == PRESC_16) ||
           (p == PRESC_32);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and bit position counter
// for the UART RX sequencer; enable plus sync clear.
module uart_rx_edge_bit_cnt #(
  parameter int PRESC_W = uart_rx_pkg::PRESC_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] last,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               wrap
);

  assign wrap = (edge_cnt == last);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (clr) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (en) begin
      if (wrap) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + PRESC_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX frame sequencer: IDLE/START/DATA/PARITY/STOP.
// Optional error counter: define UART_RX_ERR_CNT_EN.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = uart_rx_pkg::PRESC_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic               PAR_EN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               sampled_bit,
  input  logic               strt_glitch,
  input  logic               par_err,
  input  logic               stp_err,
  output logic               dat_samp_en,
  output logic               deser_en,
  output logic               strt_chk_en,
  output logic               par_chk_en,
  output logic               stp_chk_en,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               data_valid,
  output logic               frame_err
`ifdef UART_RX_ERR_CNT_EN
  ,
  input  logic               err_clr,
  output logic [7:0]         err_cnt
`endif
);
  import uart_rx_pkg::*;

  logic [2:0]         state;
  logic [2:0]         state_d;
  logic [PRESC_W-1:0] pre_q;
  logic               par_q;
  logic               bit_end;
  logic               frm_start;
  logic               legal;
  logic               dv_d;
  logic               fe_d;

  assign legal = presc_legal(int'(Prescale));

  always_comb begin
    state_d = state;
    case (state)
      IDLE:
        if (!RX_IN && legal) state_d = START;
      START:
        if (bit_end) state_d = strt_glitch ? IDLE : DATA;
      DATA:
        if (bit_end && bit_cnt == 4'(DATA_WIDTH))
          state_d = par_q ? PARITY : STOP;
      PARITY:
        if (bit_end) state_d = par_err ? IDLE : STOP;
      STOP:
        if (bit_end)
          state_d = (!RX_IN && legal) ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame settings are frozen at every new start bit
  assign frm_start = (state_d == START) &&
                     (state != START);

  assign dv_d = (state == STOP) && bit_end && !stp_err;
  assign fe_d = bit_end &&
                (((state == START) && strt_glitch) ||
                 ((state == PARITY) && par_err) ||
                 ((state == STOP) && stp_err));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      pre_q      <= '0;
      par_q      <= 1'b0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_d;
      data_valid <= dv_d;
      frame_err  <= fe_d;
      if (frm_start) begin
        pre_q <= Prescale;
        par_q <= PAR_EN;
      end
    end
  end

  uart_rx_edge_bit_cnt #(
    .PRESC_W (PRESC_W)
  ) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .en       (state != IDLE),
    .clr      ((state_d == IDLE) || frm_start),
    .last     (pre_q - PRESC_W'(1)),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .wrap     (bit_end)
  );

  assign dat_samp_en = (state != IDLE);
  assign strt_chk_en = (state == START);
  assign par_chk_en  = (state == PARITY);
  assign stp_chk_en  = (state == STOP);
  assign deser_en    = (state == DATA) &&
    (edge_cnt == (pre_q >> 1) + PRESC_W'(2));

`ifdef UART_RX_ERR_CNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      err_cnt <= '0;
    else if (err_clr)
      err_cnt <= '0;
    else if (frame_err && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule
